// File: rtl/ibex_ex_wb_stage.sv
// Writeback stage behind the execute block. It retires ALU and mult/div
// results one cycle after acceptance. It holds a load until the LSU response
// arrives, back-pressuring EX/ID meanwhile. While a load waits, it counts the
// wait cycles in a saturating counter.
module ibex_ex_wb_stage #(
  parameter int DataWidth = 32,
  parameter int RegAddrW  = 5,
  parameter int CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_instr_valid_i,
  input  logic                 ex_valid_i,
  input  logic [DataWidth-1:0] ex_result_i,
  input  logic                 ex_rf_we_i,
  input  logic [RegAddrW-1:0]  ex_rf_waddr_i,
  input  logic                 ex_is_load_i,
  output logic                 wb_ready_o,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic                 rf_we_o,
  output logic [RegAddrW-1:0]  rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 instr_done_o,
  output logic                 load_err_o,
  output logic                 outstanding_load_o,
  output logic [CntWidth-1:0]  load_wait_cycles_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALU_WB    = 2'd1,
    LOAD_WAIT = 2'd2
  } state_e;

  state_e                state;
  logic [DataWidth-1:0]  result_p1;
  logic                  we_p1;
  logic [RegAddrW-1:0]   waddr_p1;
  logic [CntWidth-1:0]   wait_cnt;
  logic                  ready;
  logic                  accept;
  logic                  resp_in_wait;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A held load blocks new work until its response cycle, which frees the slot.
  assign resp_in_wait = (state == LOAD_WAIT) && lsu_resp_valid_i;
  assign ready        = (state != LOAD_WAIT) || lsu_resp_valid_i;
  assign accept       = ex_instr_valid_i && ex_valid_i && ready;

  // FSM: the new instruction decides the next state; otherwise a load keeps waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else if (accept) begin
      state <= ex_is_load_i ? LOAD_WAIT : ALU_WB;
    end else if ((state == LOAD_WAIT) && !lsu_resp_valid_i) begin
      state <= LOAD_WAIT;
    end else begin
      state <= IDLE;
    end
  end

  // Capture the retiring instruction's result and destination on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_p1 <= '0;
      we_p1     <= 1'b0;
      waddr_p1  <= '0;
    end else if (accept) begin
      result_p1 <= ex_result_i;
      we_p1     <= ex_rf_we_i;
      waddr_p1  <= ex_rf_waddr_i;
    end
  end

  // The load wait counter restarts per load and holds after the load completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (accept && ex_is_load_i) begin
      wait_cnt <= '0;
    end else if ((state == LOAD_WAIT) && !lsu_resp_valid_i) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  // Writeback port and pulses; load data bypasses the registers in the response cycle.
  always_comb begin
    rf_we_o            = 1'b0;
    rf_wdata_o         = result_p1;
    instr_done_o       = 1'b0;
    load_err_o         = 1'b0;
    outstanding_load_o = 1'b0;
    case (state)
      ALU_WB: begin
        rf_we_o      = we_p1 && (waddr_p1 != '0);
        instr_done_o = 1'b1;
      end
      LOAD_WAIT: begin
        outstanding_load_o = 1'b1;
        rf_wdata_o         = lsu_rdata_i;
        if (resp_in_wait) begin
          rf_we_o      = we_p1 && !lsu_err_i && (waddr_p1 != '0);
          instr_done_o = 1'b1;
          load_err_o   = lsu_err_i;
        end
      end
      default: ;
    endcase
  end

  assign wb_ready_o         = ready;
  assign rf_waddr_o         = waddr_p1;
  assign load_wait_cycles_o = wait_cnt;

endmodule
